pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter TAG_W, default 9, width of the register specifiers Rd/Rs/Rt.
REQ-002 SHALL have parameter MUL_CYCLES, default 3, total EX occupancy of a multiply (range 2..15).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port id_valid, input, 1, the ID stage holds a real instruction.
REQ-006 SHALL have port id_opcode, input, 5, the ID-stage opcode.
REQ-007 SHALL have ports id_rd, id_rs and id_rt, input, TAG_W each, the ID-stage destination and sources.
REQ-008 SHALL have port ex_branch_taken, input, 1, branch resolved taken in EX this cycle.
REQ-009 SHALL have port stall, output, 1, hold PC and IF/ID this cycle (combinational).
REQ-010 SHALL have port idex_bubble, output, 1, load NOP (opcode 0) into ID/EX at the next edge (combinational).
REQ-011 SHALL have port ifid_flush, output, 1, clear IF/ID at the next edge (combinational).
REQ-012 SHALL have ports fwd_a and fwd_b, output, 2, registered operand-source selects for the instruction now in EX: 00 register file, 01 EX/MEM, 10 MEM/WB.
REQ-013 SHALL have port busy, output, 1, FSM is in MUL_WAIT (registered).

Function
REQ-014 SHALL keep three tracking slots EX, MEM and WB, each holding {valid, rd, is_load, writes}.
REQ-015 "issue" SHALL mean id_valid=1, stall=0 and idex_bubble=0; on issue EX gets the ID fields, otherwise EX gets an empty slot.
REQ-016 Each slot SHALL advance EX->MEM->WB every edge, except as stated in REQ-020.
REQ-017 writes SHALL be 0 for OP_NOP, OP_STR and OP_B and 1 for all other opcodes; tag 0 is the zero register and SHALL never match.
REQ-018 The FSM SHALL have two states, RUN and MUL_WAIT, plus a 4-bit down-counter.
REQ-019 In RUN, issuing OP_MUL SHALL move the FSM to MUL_WAIT with the counter loaded to MUL_CYCLES-1.
REQ-020 In MUL_WAIT the outputs SHALL be stall=1 and idex_bubble=0, the EX slot and ID/EX are held, and MEM receives an empty slot.
REQ-021 In MUL_WAIT the counter SHALL decrement each cycle and the FSM SHALL return to RUN on the edge where the counter reaches 0.
REQ-022 Load-use: in RUN with id_valid=1, EX.valid, EX.is_load and EX.rd matching id_rs or id_rt, the outputs SHALL be stall=1 and idex_bubble=1, for exactly one cycle.
REQ-023 Branch: in RUN with ex_branch_taken=1, the outputs SHALL be ifid_flush=1, idex_bubble=1 and stall=0.
REQ-024 Priority SHALL be MUL_WAIT > branch > load-use; ex_branch_taken SHALL be ignored in MUL_WAIT.
REQ-025 fwd_a SHALL be registered on each issue edge: 01 if id_rs matches EX.rd (EX.writes, not a load), else 10 if id_rs matches MEM.rd (MEM.writes), else 00.
REQ-026 fwd_b SHALL follow the rule of REQ-025 using id_rt.
REQ-027 fwd_a and fwd_b SHALL be held in MUL_WAIT and cleared to 00 on a bubble.
REQ-028 id_rd, id_rs and id_rt SHALL be ignored when id_valid=0.

Reset
REQ-029 While rst_n=0 the block SHALL hold FSM=RUN, counter=0, all slots invalid, fwd_a=fwd_b=00 and busy=0.
REQ-030 While rst_n=0 the combinational outputs SHALL settle to stall=0, idex_bubble=0 and ifid_flush=0.
REQ-031 Reset asserted mid-MUL_WAIT SHALL abort the multiply; after release the block starts in RUN.

Structure
REQ-032 A shared package hazard_pkg SHALL hold OP_NOP=5'd0, OP_LDR=5'd7, OP_MUL=5'd11, OP_STR=5'd3, OP_B=5'd14, the slot struct typedef, the state enum and a writes_rd(opcode) function.
REQ-033 One sub-module, hazard_slot_pipe, SHALL contain the three-slot tracking shift register with its hold input.

Verification
REQ-034 Bench SHALL issue LDR rd=9, then ADD(5'd1) rs=9 -> stall=1 and idex_bubble=1 for 1 cycle, then ADD issues with fwd_a=10.
REQ-035 Bench SHALL issue ADD rd=6, then ADD rs=6 rt=6 -> no stall, fwd_a=fwd_b=01.
REQ-036 Bench SHALL issue MUL rd=4 with MUL_CYCLES=3 -> busy=1 and stall=1 for 2 cycles, then RUN.
REQ-037 Bench SHALL apply ex_branch_taken=1 together with a load-use match -> ifid_flush=1, idex_bubble=1, stall=0.
REQ-038 Bench SHALL assert rst_n=0 one cycle into MUL_WAIT -> busy=0, fwd=00 and slots empty immediately; a subsequent ADD rs=4 issues with no stall and fwd_a=00.
REQ-039 Bench SHALL issue ADD with rd=0, then ADD rs=0 -> no stall, fwd_a=00.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared opcodes, tracking-slot layout and FSM state encoding for the
// pipeline hazard controller.
package hazard_pkg;

  localparam logic [4:0] OP_NOP = 5'd0;
  localparam logic [4:0] OP_STR = 5'd3;
  localparam logic [4:0] OP_LDR = 5'd7;
  localparam logic [4:0] OP_MUL = 5'd11;
  localparam logic [4:0] OP_B   = 5'd14;

  // Slots store tags at a fixed width so the struct can live in the package;
  // narrower tags are zero-extended on entry.
  localparam int TAG_W_MAX = 16;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W_MAX-1:0] rd;
    logic                 is_load;
    logic                 writes;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '0;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MUL_WAIT = 1'b1
  } state_t;

  function automatic logic writes_rd(input logic [4:0] opcode);
    return !(opcode inside {OP_NOP, OP_STR, OP_B});
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the ID/EX datapath (master) and the hazard
// controller (slave).
interface pipeline_hazard_ctrl_if #(
  parameter int TAG_W = 9
);

  logic             id_valid;
  logic [4:0]       id_opcode;
  logic [TAG_W-1:0] id_rd;
  logic [TAG_W-1:0] id_rs;
  logic [TAG_W-1:0] id_rt;
  logic             ex_branch_taken;
  logic             stall;
  logic             idex_bubble;
  logic             ifid_flush;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             busy;

  modport master (
    output id_valid, id_opcode, id_rd, id_rs, id_rt, ex_branch_taken,
    input  stall, idex_bubble, ifid_flush, fwd_a, fwd_b, busy
  );

  modport slave (
    input  id_valid, id_opcode, id_rd, id_rs, id_rt, ex_branch_taken,
    output stall, idex_bubble, ifid_flush, fwd_a, fwd_b, busy
  );

endinterface

// File: rtl/hazard_slot_pipe.sv
// Three-deep EX/MEM/WB destination tracker. While hold is high the EX slot
// keeps its multiply and an empty slot drains into MEM.
module hazard_slot_pipe
  import hazard_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  hold,
  input  slot_t ex_next,
  output slot_t ex,
  output slot_t mem,
  output slot_t wb
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex  <= SLOT_EMPTY;
      mem <= SLOT_EMPTY;
      wb  <= SLOT_EMPTY;
    end else if (hold) begin
      mem <= SLOT_EMPTY;
      wb  <= mem;
    end else begin
      ex  <= ex_next;
      mem <= ex;
      wb  <= mem;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/bubble/flush generation and operand-forwarding selects for a
// five-stage pipeline with a multi-cycle multiplier in EX.
//
// state       | meaning
// ST_RUN      | normal issue; branch flush and load-use stall evaluated
// ST_MUL_WAIT | multiply occupying EX; front end stalled, counter running
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int TAG_W      = 9,
  parameter int MUL_CYCLES = 3
) (
  input logic                   clk,
  input logic                   rst_n,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  slot_t            ex_slot, mem_slot, wb_slot_unused, ex_next;
  logic [TAG_W-1:0] rd, rs, rt;
  logic             mul_wait, branch, load_use, issue;
  logic             stall, bubble, flush;

  function automatic logic tag_hit(input slot_t s, input logic [TAG_W-1:0] tag);
    return s.valid && (tag != '0) && (s.rd == TAG_W_MAX'(tag));
  endfunction

  function automatic logic [1:0] fwd_sel(input slot_t ex_s, input slot_t mem_s,
                                         input logic [TAG_W-1:0] tag);
    if (tag_hit(ex_s, tag) && ex_s.writes && !ex_s.is_load) return FWD_EX;
    if (tag_hit(mem_s, tag) && mem_s.writes)                return FWD_MEM;
    return FWD_RF;
  endfunction

  // Register specifiers are meaningless without a valid instruction.
  assign rd = hz.id_valid ? hz.id_rd : '0;
  assign rs = hz.id_valid ? hz.id_rs : '0;
  assign rt = hz.id_valid ? hz.id_rt : '0;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fwd_a_d  = fwd_a_q;
    fwd_b_d  = fwd_b_q;
    ex_next  = SLOT_EMPTY;
    mul_wait = (state_q == ST_MUL_WAIT);
    branch   = hz.ex_branch_taken && rst_n;
    load_use = hz.id_valid && ex_slot.is_load &&
               (tag_hit(ex_slot, rs) || tag_hit(ex_slot, rt));

    stall  = mul_wait || (!branch && load_use);
    bubble = !mul_wait && (branch || load_use);
    flush  = !mul_wait && branch;
    issue  = hz.id_valid && !stall && !bubble;

    if (issue) begin
      ex_next.valid   = 1'b1;
      ex_next.rd      = TAG_W_MAX'(rd);
      ex_next.is_load = (hz.id_opcode == OP_LDR);
      ex_next.writes  = writes_rd(hz.id_opcode);
    end

    if (!mul_wait) begin
      if (issue) begin
        fwd_a_d = fwd_sel(ex_slot, mem_slot, rs);
        fwd_b_d = fwd_sel(ex_slot, mem_slot, rt);
      end else begin
        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
      end
    end

    case (state_q)
      ST_RUN: begin
        if (issue && hz.id_opcode == OP_MUL) begin
          state_d = ST_MUL_WAIT;
          cnt_d   = 4'(MUL_CYCLES - 1);
        end
      end
      ST_MUL_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_d == 4'd0) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  // WB is tracked to keep the slot model complete; nothing here consumes it.
  hazard_slot_pipe u_slots (
    .clk     (clk),
    .rst_n   (rst_n),
    .hold    (mul_wait),
    .ex_next (ex_next),
    .ex      (ex_slot),
    .mem     (mem_slot),
    .wb      (wb_slot_unused)
  );

  assign hz.stall       = stall;
  assign hz.idex_bubble = bubble;
  assign hz.ifid_flush  = flush;
  assign hz.fwd_a       = fwd_a_q;
  assign hz.fwd_b       = fwd_b_q;
  assign hz.busy        = (state_q == ST_MUL_WAIT);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: each stimulus cycle queues its expected outputs and a
// negedge monitor pops and compares them against the DUT.
module tb_pipeline_hazard_ctrl;
  import hazard_pkg::*;

  localparam int TAG_W = 9;
  localparam logic [4:0] OP_ADD = 5'd1;
  localparam logic [7:0] M_ALL = 8'hFF;
  localparam logic [7:0] M_CTL = 8'hF0;

  typedef struct {
    string      name;
    logic [7:0] val;
    logic [7:0] mask;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t sb_q[$];
  exp_t mon_x;
  logic [7:0] mon_got;
  int n_checks = 0;
  int n_pass = 0;

  pipeline_hazard_ctrl_if #(.TAG_W(TAG_W)) hz ();

  pipeline_hazard_ctrl #(.TAG_W(TAG_W), .MUL_CYCLES(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz.slave)
  );

  always #5 clk = ~clk;

  // {stall, idex_bubble, ifid_flush, busy, fwd_a, fwd_b}
  function automatic logic [7:0] ev(input logic s, input logic b, input logic f,
                                    input logic bu, input logic [1:0] fa,
                                    input logic [1:0] fb);
    return {s, b, f, bu, fa, fb};
  endfunction

  task automatic cyc(input string nm, input logic v, input logic [4:0] op,
                     input int rd, input int rs, input int rt, input logic br,
                     input logic [7:0] e, input logic [7:0] m);
    exp_t x;
    hz.id_valid        = v;
    hz.id_opcode       = op;
    hz.id_rd           = TAG_W'(rd);
    hz.id_rs           = TAG_W'(rs);
    hz.id_rt           = TAG_W'(rt);
    hz.ex_branch_taken = br;
    x.name = nm;
    x.val  = e;
    x.mask = m;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cyc("idle", 1'b0, OP_NOP, 0, 0, 0, 1'b0, ev(0, 0, 0, 0, 2'b00, 2'b00), M_CTL);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_x   = sb_q.pop_front();
      mon_got = {hz.stall, hz.idex_bubble, hz.ifid_flush, hz.busy, hz.fwd_a, hz.fwd_b};
      n_checks++;
      if ((mon_got & mon_x.mask) === (mon_x.val & mon_x.mask))
        n_pass++;
      else
        $display("FAIL %s: got %b expected %b (mask %b) at %0t",
                 mon_x.name, mon_got, mon_x.val, mon_x.mask, $time);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    hz.id_valid        = 1'b0;
    hz.id_opcode       = OP_NOP;
    hz.id_rd           = '0;
    hz.id_rs           = '0;
    hz.id_rt           = '0;
    hz.ex_branch_taken = 1'b0;
    rst_n              = 1'b0;
    @(posedge clk);
    #1;

    // Reset: combinational outputs quiet even with a taken branch applied
    cyc("rst_outputs", 1'b0, OP_NOP, 0, 0, 0, 1'b1, ev(0, 0, 0, 0, 2'b00, 2'b00), M_ALL);
    rst_n = 1'b1;
    idle(2);

    // Load-use on rs, then forward from MEM/WB
    cyc("ldr_issue",       1'b1, OP_LDR, 9, 1, 2, 1'b0, ev(0, 0, 0, 0, 2'b00, 2'b00), M_CTL);
    cyc("loaduse_stall",   1'b1, OP_ADD, 10, 9, 3, 1'b0, ev(1, 1, 0, 0, 2'b00, 2'b00), M_ALL);
    cyc("loaduse_release", 1'b1, OP_ADD, 10, 9, 3, 1'b0, ev(0, 0, 0, 0, 2'b00, 2'b00), M_ALL);
    cyc("loaduse_fwd",     1'b0, OP_NOP, 0, 0, 0, 1'b0, ev(0, 0, 0, 0, 2'b10, 2'b00), M_ALL);
    idle(3);

    // Back-to-back ALU dependency forwards from EX/MEM on both operands
    cyc("add6_issue", 1'b1, OP_ADD, 6, 1, 2, 1'b0, ev(0, 0, 0, 0, 2'b00, 2'b00), M_CTL);
    cyc("add6_dep",   1'b1, OP_ADD, 7, 6, 6, 1'b0, ev(0, 0, 0, 0, 2'b00, 2'b00), M_ALL);
    cyc("ex_fwd",     1'b0, OP_NOP, 0, 0, 0, 1'b0, ev(0, 0, 0, 0, 2'b01, 2'b01), M_ALL);
    idle(3);

    // Mixed sources: rs from MEM, rt from EX
    cyc("add5_issue", 1'b1, OP_ADD, 5, 1, 2, 1'b0, ev(0, 0, 0, 0, 2'b00, 2'b00), M_CTL);
    cyc("add8_issue", 1'b1, OP_ADD, 8, 3, 3, 1'b0, ev(0, 0, 0, 0, 2'b00, 2'b00), M_ALL);
    cyc("mix_issue",  1'b1, OP_ADD, 11, 5, 8, 1'b0, ev(0, 0, 0, 0, 2'b00, 2'b00), M_ALL);
    cyc("mem_ex_fwd", 1'b0, OP_NOP, 0, 0, 0, 1'b0, ev(0, 0, 0, 0, 2'b10, 2'b01), M_ALL);
    idle(3);

    // Multiply: two MUL_WAIT cycles, branch ignored while waiting
    cyc("mul_issue",    1'b1, OP_MUL, 4, 1, 2, 1'b0, ev(0, 0, 0, 0, 2'b00, 2'b00), M_CTL);
    cyc("mul_wait1",    1'b1, OP_ADD, 9, 4, 3, 1'b0, ev(1, 0, 0, 1, 2'b00, 2'b00), M_ALL);
    cyc("mul_wait2_br", 1'b1, OP_ADD, 9, 4, 3, 1'b1, ev(1, 0, 0, 1, 2'b00, 2'b00), M_ALL);
    cyc("mul_done",     1'b1, OP_ADD, 9, 4, 3, 1'b0, ev(0, 0, 0, 0, 2'b00, 2'b00), M_ALL);
    cyc("mul_fwd",      1'b0, OP_NOP, 0, 0, 0, 1'b0, ev(0, 0, 0, 0, 2'b01, 2'b00), M_ALL);
    idle(3);

    // Branch wins over a load-use match on rt
    cyc("ldr2_issue",     1'b1, OP_LDR, 9, 1, 2, 1'b0, ev(0, 0, 0, 0, 2'b00, 2'b00), M_CTL);
    cyc("branch_over_lu", 1'b1, OP_ADD, 10, 3, 9, 1'b1, ev(0, 1, 1, 0, 2'b00, 2'b00), M_ALL);
    cyc("branch_after",   1'b0, OP_NOP, 0, 0, 0, 1'b0, ev(0, 0, 0, 0, 2'b00, 2'b00), M_ALL);
    idle(3);

    // Reset mid-multiply aborts it
    cyc("mul2_issue", 1'b1, OP_MUL, 4, 1, 2, 1'b0, ev(0, 0, 0, 0, 2'b00, 2'b00), M_CTL);
    cyc("mul2_wait",  1'b1, OP_ADD, 9, 4, 3, 1'b0, ev(1, 0, 0, 1, 2'b00, 2'b00), M_ALL);
    rst_n = 1'b0;
    cyc("rst_abort",  1'b1, OP_ADD, 9, 4, 3, 1'b0, ev(0, 0, 0, 0, 2'b00, 2'b00), M_ALL);
    rst_n = 1'b1;
    cyc("post_rst_issue", 1'b1, OP_ADD, 9, 4, 3, 1'b0, ev(0, 0, 0, 0, 2'b00, 2'b00), M_ALL);
    cyc("post_rst_fwd",   1'b0, OP_NOP, 0, 0, 0, 1'b0, ev(0, 0, 0, 0, 2'b00, 2'b00), M_ALL);
    idle(3);

    // Zero register never matches, for ALU results or loads
    cyc("add_r0",     1'b1, OP_ADD, 0, 1, 2, 1'b0, ev(0, 0, 0, 0, 2'b00, 2'b00), M_CTL);
    cyc("use_r0",     1'b1, OP_ADD, 7, 0, 0, 1'b0, ev(0, 0, 0, 0, 2'b00, 2'b00), M_ALL);
    cyc("r0_fwd",     1'b0, OP_NOP, 0, 0, 0, 1'b0, ev(0, 0, 0, 0, 2'b00, 2'b00), M_ALL);
    cyc("ldr_r0",     1'b1, OP_LDR, 0, 1, 2, 1'b0, ev(0, 0, 0, 0, 2'b00, 2'b00), M_CTL);
    cyc("use_ldr_r0", 1'b1, OP_ADD, 7, 0, 0, 1'b0, ev(0, 0, 0, 0, 2'b00, 2'b00), M_ALL);
    idle(3);

    // Specifiers ignored without id_valid
    cyc("ldr3_issue",      1'b1, OP_LDR, 9, 1, 2, 1'b0, ev(0, 0, 0, 0, 2'b00, 2'b00), M_CTL);
    cyc("invalid_ignored", 1'b0, OP_ADD, 10, 9, 9, 1'b0, ev(0, 0, 0, 0, 2'b00, 2'b00), M_ALL);
    idle(2);

    repeat (2) @(posedge clk);
    if (sb_q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
